// File: rtl/vball_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vball_pkg
// Description : Shared types and constants for the VBall ROM loader.
//               Loader FSM states, address-region codes, default ROM
//               region sizes and the ioctl indices used by the loader.
// Revision    : 1.0 - initial release
// ============================================================================
package vball_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SD_REQ  = 2'd1,
    SD_WAIT = 2'd2
  } ld_state_t;

  // Destination region of a blob byte
  typedef enum logic [1:0] {
    REG_MAIN = 2'd0,
    REG_SND  = 2'd1,
    REG_GFX  = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  localparam int unsigned DEF_MAIN_SIZE = 32'h0001_0000;
  localparam int unsigned DEF_SND_SIZE  = 32'h0000_8000;

  localparam int unsigned ROM_INDEX = 0;
  localparam int unsigned DIP_INDEX = 254;

endpackage
`default_nettype wire

// File: rtl/rom_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : rom_loader_if
// Description : hps_io ioctl download port. The master modport is the
//               hps_io side, the slave modport is the loader side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output ioctl_wait
  );
endinterface
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
// Module      : rom_region_decode
// Description : Combinational blob-offset decoder. Classifies a 25-bit blob
//               offset as main-CPU ROM, sound-CPU ROM or graphics ROM and
//               returns the offset relative to the start of that region.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_region_decode #(
  parameter int unsigned MAIN_SIZE = vball_pkg::DEF_MAIN_SIZE,
  parameter int unsigned GFX_BASE  = vball_pkg::DEF_MAIN_SIZE + vball_pkg::DEF_SND_SIZE
) (
  input  logic [24:0]       addr,
  output vball_pkg::region_t region,
  output logic [24:0]       offset
);
  import vball_pkg::*;

  localparam logic [24:0] C_MAIN_END = 25'(MAIN_SIZE);
  localparam logic [24:0] C_GFX_BASE = 25'(GFX_BASE);

  // Graphics is the catch-all: it is unbounded above GFX_BASE
  always_comb begin
    region = REG_GFX;
    offset = addr - C_GFX_BASE;
    if (addr < C_MAIN_END) begin
      region = REG_MAIN;
      offset = addr;
    end else if (addr < C_GFX_BASE) begin
      region = REG_SND;
      offset = addr - C_MAIN_END;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Routes the hps_io index-0 ROM blob into the main-CPU and
//               sound-CPU BRAMs and the graphics SDRAM, stalling hps_io
//               while an SDRAM write is outstanding. Captures index-254
//               DIP bytes and flags blob completion.
//               Optional macro ROM_LOADER_CHECKSUM_EN adds a 16-bit running
//               sum of accepted index-0 bytes on output cksum.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
  parameter int unsigned MAIN_SIZE = vball_pkg::DEF_MAIN_SIZE,
  parameter int unsigned SND_SIZE  = vball_pkg::DEF_SND_SIZE,
  parameter int unsigned GFX_BASE  = MAIN_SIZE + SND_SIZE,
  parameter int unsigned DIP_INDEX = vball_pkg::DIP_INDEX
) (
  input  logic               clk_sys,
  input  logic               reset,
  rom_loader_if.slave        ioctl,
  output logic [24:0]        sd_addr,
  output logic [7:0]         sd_din,
  output logic               sd_we,
  input  logic               sd_ready,
  output logic [15:0]        rom_addr,
  output logic [7:0]         rom_data,
  output logic               main_we,
  output logic               snd_we,
  output logic [7:0]         dsw1,
  output logic [7:0]         dsw2,
  output logic               load_done,
  output logic               err_overrun
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]        cksum
`endif
);
  import vball_pkg::*;

  localparam logic [7:0] C_ROM_IDX = 8'(ROM_INDEX);
  localparam logic [7:0] C_DIP_IDX = 8'(DIP_INDEX);

  ld_state_t   state_q, state_d;
  logic        ioctl_wait_q, ioctl_wait_d;
  logic        sd_we_q, sd_we_d;
  logic        main_we_q, main_we_d;
  logic        snd_we_q, snd_we_d;
  logic [24:0] sd_addr_q, sd_addr_d;
  logic [7:0]  sd_din_q, sd_din_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [7:0]  dsw1_q, dsw1_d;
  logic [7:0]  dsw2_q, dsw2_d;
  logic        load_done_q, load_done_d;
  logic        done_pend_q, done_pend_d;
  logic        err_overrun_q, err_overrun_d;
  logic        dl_q, dl_d;
  logic        dl0_q, dl0_d;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] cksum_q, cksum_d;
`endif

  region_t     region;
  logic [24:0] offset;
  logic        rom_wr;
  logic        accept;
  logic        dl_rise0;
  logic        dl_fall0;

  rom_region_decode #(
    .MAIN_SIZE (MAIN_SIZE),
    .GFX_BASE  (GFX_BASE)
  ) u_decode (
    .addr   (ioctl.ioctl_addr),
    .region (region),
    .offset (offset)
  );

  // Next-state computation for the FSM, strobes, DIP latches and status flags
  always_comb begin
    rom_wr   = ioctl.ioctl_wr && (ioctl.ioctl_index == C_ROM_IDX);
    accept   = rom_wr && ioctl.ioctl_download && (state_q == IDLE);
    dl_rise0 = ioctl.ioctl_download && !dl_q && (ioctl.ioctl_index == C_ROM_IDX);
    dl_fall0 = !ioctl.ioctl_download && dl0_q;

    state_d       = state_q;
    ioctl_wait_d  = ioctl_wait_q;
    sd_we_d       = 1'b0;
    main_we_d     = 1'b0;
    snd_we_d      = 1'b0;
    sd_addr_d     = sd_addr_q;
    sd_din_d      = sd_din_q;
    rom_addr_d    = rom_addr_q;
    rom_data_d    = rom_data_q;
    dsw1_d        = dsw1_q;
    dsw2_d        = dsw2_q;
    load_done_d   = load_done_q;
    done_pend_d   = done_pend_q;
    err_overrun_d = err_overrun_q;
    dl_d          = ioctl.ioctl_download;
    dl0_d         = ioctl.ioctl_download && (ioctl.ioctl_index == C_ROM_IDX);
`ifdef ROM_LOADER_CHECKSUM_EN
    cksum_d       = (dl_rise0 ? 16'h0000 : cksum_q) +
                    (accept ? {8'h00, ioctl.ioctl_dout} : 16'h0000);
`endif

    unique case (state_q)
      IDLE: begin
        ioctl_wait_d = 1'b0;
        if (accept) begin
          unique case (region)
            REG_MAIN: begin
              main_we_d  = 1'b1;
              rom_addr_d = offset[15:0];
              rom_data_d = ioctl.ioctl_dout;
            end
            REG_SND: begin
              snd_we_d   = 1'b1;
              rom_addr_d = offset[15:0];
              rom_data_d = ioctl.ioctl_dout;
            end
            REG_GFX: begin
              state_d      = SD_REQ;
              sd_we_d      = 1'b1;
              sd_addr_d    = offset;
              sd_din_d     = ioctl.ioctl_dout;
              ioctl_wait_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      // An acknowledge coinciding with the request is honoured immediately
      SD_REQ: begin
        if (sd_ready) begin
          state_d      = IDLE;
          ioctl_wait_d = 1'b0;
        end else begin
          state_d = SD_WAIT;
        end
      end
      SD_WAIT: begin
        if (sd_ready) begin
          state_d      = IDLE;
          ioctl_wait_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        ioctl_wait_d = 1'b0;
      end
    endcase

    // A ROM byte arriving while an SDRAM write is outstanding is lost
    if (dl_rise0) err_overrun_d = 1'b0;
    if (rom_wr && (state_q != IDLE)) err_overrun_d = 1'b1;

    // DIP bytes live at offsets 0 and 1; accepted regardless of FSM state
    if (ioctl.ioctl_wr && (ioctl.ioctl_index == C_DIP_IDX) &&
        (ioctl.ioctl_addr[24:3] == 22'd0)) begin
      if (ioctl.ioctl_addr[2:0] == 3'd0) dsw1_d = ioctl.ioctl_dout;
      if (ioctl.ioctl_addr[2:0] == 3'd1) dsw2_d = ioctl.ioctl_dout;
    end

    // Completion waits for any in-flight SDRAM write to drain
    if (dl_rise0) begin
      load_done_d = 1'b0;
      done_pend_d = 1'b0;
    end
    if (dl_fall0) begin
      if (state_q == IDLE) load_done_d = 1'b1;
      else                 done_pend_d = 1'b1;
    end
    if (done_pend_q && (state_q == IDLE)) begin
      load_done_d = 1'b1;
      done_pend_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      ioctl_wait_q  <= 1'b0;
      sd_we_q       <= 1'b0;
      main_we_q     <= 1'b0;
      snd_we_q      <= 1'b0;
      sd_addr_q     <= '0;
      sd_din_q      <= '0;
      rom_addr_q    <= '0;
      rom_data_q    <= '0;
      dsw1_q        <= 8'hFF;
      dsw2_q        <= 8'hFF;
      load_done_q   <= 1'b0;
      done_pend_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      dl_q          <= 1'b0;
      dl0_q         <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      cksum_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ioctl_wait_q  <= ioctl_wait_d;
      sd_we_q       <= sd_we_d;
      main_we_q     <= main_we_d;
      snd_we_q      <= snd_we_d;
      sd_addr_q     <= sd_addr_d;
      sd_din_q      <= sd_din_d;
      rom_addr_q    <= rom_addr_d;
      rom_data_q    <= rom_data_d;
      dsw1_q        <= dsw1_d;
      dsw2_q        <= dsw2_d;
      load_done_q   <= load_done_d;
      done_pend_q   <= done_pend_d;
      err_overrun_q <= err_overrun_d;
      dl_q          <= dl_d;
      dl0_q         <= dl0_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      cksum_q       <= cksum_d;
`endif
    end
  end

  assign ioctl.ioctl_wait = ioctl_wait_q;
  assign sd_addr          = sd_addr_q;
  assign sd_din           = sd_din_q;
  assign sd_we            = sd_we_q;
  assign rom_addr         = rom_addr_q;
  assign rom_data         = rom_data_q;
  assign main_we          = main_we_q;
  assign snd_we           = snd_we_q;
  assign dsw1             = dsw1_q;
  assign dsw2             = dsw2_q;
  assign load_done        = load_done_q;
  assign err_overrun      = err_overrun_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  assign cksum            = cksum_q;
`endif

endmodule
`default_nettype wire

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sits between hps_io's ioctl download port and the VBall memories; downstream of hps_io, upstream of sdram and the vball core's CPU ROM BRAMs.
- Decodes the index-0 ROM blob by address into three regions:
  - main-CPU ROM (BRAM write port)
  - sound-CPU ROM (BRAM write port)
  - graphics ROM (SDRAM)
- Holds ioctl_wait while each SDRAM write is outstanding.
- Captures index-254 DIP bytes and flags download completion.

Parameters:
- MAIN_SIZE, 'h10000: bytes of main-CPU ROM at blob offset 0.
- SND_SIZE, 'h08000: bytes of sound-CPU ROM immediately after main ROM.
- GFX_BASE, MAIN_SIZE+SND_SIZE: blob offset where graphics ROM starts; mapped to SDRAM address 0.
- DIP_INDEX, 254: ioctl_index carrying DIP switch bytes.

Ports:
- clk_sys in 1: system clock.
- reset in 1: synchronous active-high reset (driven from RESET | ~locked; must NOT include ioctl_download).
- ioctl_download in 1: download active.
- ioctl_wr in 1: one-cycle byte strobe.
- ioctl_index in 8: download index.
- ioctl_addr in 25: byte offset.
- ioctl_dout in 8: byte data.
- ioctl_wait out 1: stall request to hps_io.
- sd_addr out 25: SDRAM byte address.
- sd_din out 8: SDRAM write data.
- sd_we out 1: one-cycle SDRAM write request.
- sd_ready in 1: one-cycle SDRAM write-complete acknowledge.
- rom_addr out 16: BRAM write address, region-relative.
- rom_data out 8: BRAM write data.
- main_we out 1: main ROM BRAM write strobe.
- snd_we out 1: sound ROM BRAM write strobe.
- dsw1 out 8: DIP byte 0.
- dsw2 out 8: DIP byte 1.
- load_done out 1: ROM blob fully loaded.
- err_overrun out 1: sticky; ioctl_wr arrived while busy.

Behaviour:
- Reset values:
  - ioctl_wait, sd_we, main_we, snd_we, load_done, err_overrun = 0.
  - sd_addr, rom_addr = 0; sd_din, rom_data = 0.
  - dsw1 = dsw2 = 8'hFF.
  - FSM = IDLE.
- FSM states: IDLE, SD_REQ, SD_WAIT.
- Decode applies only in IDLE, on cycle N where ioctl_wr && ioctl_download && ioctl_index==0:
  - addr < MAIN_SIZE: cycle N+1 main_we=1, rom_addr=addr[15:0], rom_data=dout; stay IDLE; no wait.
  - MAIN_SIZE <= addr < GFX_BASE: cycle N+1 snd_we=1, rom_addr=addr-MAIN_SIZE (16-bit); stay IDLE.
  - addr >= GFX_BASE: cycle N+1 state SD_REQ, sd_we=1, sd_addr=addr-GFX_BASE, sd_din=dout, ioctl_wait=1. Cycle N+2 state SD_WAIT, sd_we=0, ioctl_wait stays 1.
  - SD_WAIT: on sd_ready go to IDLE and drop ioctl_wait on the following cycle.
  - sd_ready during SD_REQ (same cycle as sd_we) is accepted: go directly to IDLE.
- DIP capture: ioctl_wr with ioctl_index==DIP_INDEX and addr[24:3]==0.
  - addr[2:0]==0 writes dsw1; ==1 writes dsw2; others ignored. Update at N+1.
  - Honoured in any state; never asserts wait.
- Other indices: ignored.
- Strobe widths: main_we/snd_we/sd_we are exactly one cycle wide.
- Overrun: ioctl_wr for index 0 while state != IDLE is dropped and sets err_overrun. err_overrun clears on reset or on the rising edge of an index-0 ioctl_download.
- load_done:
  - Cleared on the rising edge of ioctl_download when ioctl_index==0.
  - Set on the first cycle where ioctl_download is low, the previous ioctl_download was high with index 0, and state==IDLE.
  - If still in SD_WAIT at the falling edge, set when IDLE is reached.
- Download dropped mid SD_WAIT: the outstanding SDRAM write still completes; FSM does not abort.
- Reset mid-operation: FSM forced to IDLE, ioctl_wait released next cycle, pending write discarded.
- Address arithmetic: 25-bit unsigned. Blob offsets >= 2^25 cannot occur. Graphics region is unbounded above GFX_BASE.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- When defined: extra output cksum [15:0].
  - Modulo-2^16 sum of every index-0 byte accepted (including BRAM and SDRAM bytes; dropped overrun bytes excluded).
  - Cleared at download start; valid when load_done=1.
- When undefined: port and adder are absent; no other behaviour changes.

Decomposition:
- Shared package vball_pkg:
  - FSM state enum (IDLE/SD_REQ/SD_WAIT).
  - Region enum (REG_MAIN/REG_SND/REG_GFX/REG_NONE).
  - Default size constants.
  - ROM_INDEX=0, DIP_INDEX=254.
- One natural sub-module: rom_region_decode. Combinational address → region plus region-relative offset; reused by the testbench model.

Test Plan:
- Write index-0 byte 'hA5 at addr 'h00010 → next cycle main_we=1, rom_addr='h0010, rom_data='hA5; ioctl_wait never high.
- Write 'h3C at addr 'h10004 → next cycle snd_we=1, rom_addr='h0004; main_we=0.
- Write 'h7E at addr 'h18020, sd_ready returned 3 cycles after sd_we → sd_addr='h20, sd_din='h7E; sd_we high 1 cycle; ioctl_wait high 4 cycles, low cycle after sd_ready.
- Second ioctl_wr while in SD_WAIT → byte dropped, err_overrun=1; no second sd_we.
- Index 254, addr 0 data 'h12, addr 1 data 'h34, addr 9 data 'hFF → dsw1='h12, dsw2='h34; no change from addr 9.
- Full blob: download high, last byte to gfx region, ioctl_download falls during SD_WAIT → load_done rises one cycle after IDLE; with ROM_LOADER_CHECKSUM_EN, cksum equals the bench-computed sum.
